// File: rtl/vram_arbiter.sv
// Video RAM arbiter: shares a single-port synchronous VRAM between display
// character/attribute fetches and host CPU accesses on a fixed 8-slot schedule.
//
// state  | meaning
// S_IDLE | no line fetch in progress; host may use every slot
// S_LINE | line fetch window; slots 2 and 6 reserved for display reads
module vram_arbiter #(
   parameter int COLS   = 80,
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetchStart,
   input  logic [ADDR_W-1:0] rowBase,
   input  logic              hostReq,
   input  logic              hostWe,
   input  logic [ADDR_W-1:0] hostAddr,
   input  logic [DATA_W-1:0] hostWData,
   output logic              hostAck,
   output logic [DATA_W-1:0] hostRData,
   output logic [ADDR_W-1:0] ramAddr,
   output logic              ramWe,
   output logic [DATA_W-1:0] ramWData,
   input  logic [DATA_W-1:0] ramRData,
   output logic [DATA_W-1:0] readoutData,
   output logic [2:0]        readoutCount,
   output logic              active
);

   localparam int COL_W = $clog2(COLS + 1);

   typedef enum logic {S_IDLE, S_LINE} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [2:0]          r_count;
   logic [ADDR_W-1:0]   r_base;
   logic [COL_W-1:0]    r_col;
   logic                r_busy;
   logic                r_host_slot;
   logic                r_host_rd;
   logic                r_ack;
   logic                r_ack_rd;
   logic [DATA_W-1:0]   r_rdata;
   logic [ADDR_W-1:0]   r_ram_addr;
   logic                r_ram_we;
   logic [DATA_W-1:0]   r_ram_wdata;

   logic                w_active;
   logic                w_line_start;
   logic                w_line_end;
   logic                w_disp_next;
   logic                w_grant;
   logic [COL_W-1:0]    w_col_inc;
   logic [ADDR_W-1:0]   w_disp_addr;

   assign w_active     = (r_state == S_LINE);
   assign w_col_inc    = r_col + 1'b1;
   assign w_line_start = (r_count == 3'd7) && !w_active && fetchStart;
   assign w_line_end   = (r_count == 3'd7) && w_active && (w_col_inc == COL_W'(COLS));

   // Decisions are made one slot ahead: slot 1 schedules the character read,
   // slot 5 schedules the attribute read at the following odd address.
   assign w_disp_next = w_active && ((r_count == 3'd1) || (r_count == 3'd5));
   assign w_disp_addr = r_base + (ADDR_W'(r_col) << 1) + ADDR_W'(r_count == 3'd5);
   assign w_grant     = !w_disp_next && hostReq && !r_busy && !r_ack;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_line_start) w_state_nxt = S_LINE;
         S_LINE: if (w_line_end)   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_count <= 3'd0;
         r_base  <= '0;
         r_col   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= r_count + 3'd1;
         if (w_line_start) begin
            r_base <= rowBase;
            r_col  <= '0;
         end else if (w_active && (r_count == 3'd7)) begin
            r_col <= w_col_inc;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ram_addr  <= '0;
         r_ram_we    <= 1'b0;
         r_ram_wdata <= '0;
      end else if (w_disp_next) begin
         r_ram_addr <= w_disp_addr;
         r_ram_we   <= 1'b0;
      end else if (w_grant) begin
         r_ram_addr  <= hostAddr;
         r_ram_we    <= hostWe;
         r_ram_wdata <= hostWData;
      end else begin
         r_ram_we <= 1'b0;
      end
   end

   // busy covers the grant slot and the ack slot, so a held request is never re-granted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy      <= 1'b0;
         r_host_slot <= 1'b0;
         r_host_rd   <= 1'b0;
         r_ack       <= 1'b0;
         r_ack_rd    <= 1'b0;
         r_rdata     <= '0;
      end else begin
         r_host_slot <= w_grant;
         r_host_rd   <= w_grant && !hostWe;
         r_ack       <= r_host_slot;
         r_ack_rd    <= r_host_rd;
         if (w_grant)
            r_busy <= 1'b1;
         else if (r_ack)
            r_busy <= 1'b0;
         if (r_ack && r_ack_rd)
            r_rdata <= ramRData;
      end
   end

   // Read data arrives during the ack cycle itself, so it is forwarded live then held.
   assign hostRData    = (r_ack && r_ack_rd) ? ramRData : r_rdata;
   assign hostAck      = r_ack;
   assign ramAddr      = r_ram_addr;
   assign ramWe        = r_ram_we;
   assign ramWData     = r_ram_wdata;
   assign readoutData  = ramRData;
   assign readoutCount = r_count;
   assign active       = w_active;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter: slot counter, line fetch
// window and addresses, host arbitration, address wrap and mid-line reset.
module tb_vram_arbiter;

   logic        clk;
   logic        rst;
   logic        fetchStart;
   logic [11:0] rowBase;
   logic        hostReq;
   logic        hostWe;
   logic [11:0] hostAddr;
   logic [7:0]  hostWData;
   logic        hostAck;
   logic [7:0]  hostRData;
   logic [11:0] ramAddr;
   logic        ramWe;
   logic [7:0]  ramWData;
   logic [7:0]  ramRData;
   logic [7:0]  readoutData;
   logic [2:0]  readoutCount;
   logic        active;

   logic        fetchStart2;
   logic [11:0] rowBase2;
   logic        zero1;
   logic [11:0] zero12;
   logic [7:0]  zero8;
   logic        hostAck2;
   logic [7:0]  hostRData2;
   logic [11:0] ramAddr2;
   logic        ramWe2;
   logic [7:0]  ramWData2;
   logic [7:0]  readoutData2;
   logic [2:0]  readoutCount2;
   logic        active2;

   int total = 0;
   int bad   = 0;

   vram_arbiter #(.COLS(80), .ADDR_W(12), .DATA_W(8)) dut (
      .clk(clk), .rst(rst), .fetchStart(fetchStart), .rowBase(rowBase),
      .hostReq(hostReq), .hostWe(hostWe), .hostAddr(hostAddr), .hostWData(hostWData),
      .hostAck(hostAck), .hostRData(hostRData), .ramAddr(ramAddr), .ramWe(ramWe),
      .ramWData(ramWData), .ramRData(ramRData), .readoutData(readoutData),
      .readoutCount(readoutCount), .active(active)
   );

   vram_arbiter #(.COLS(2), .ADDR_W(12), .DATA_W(8)) dut2 (
      .clk(clk), .rst(rst), .fetchStart(fetchStart2), .rowBase(rowBase2),
      .hostReq(zero1), .hostWe(zero1), .hostAddr(zero12), .hostWData(zero8),
      .hostAck(hostAck2), .hostRData(hostRData2), .ramAddr(ramAddr2), .ramWe(ramWe2),
      .ramWData(ramWData2), .ramRData(zero8), .readoutData(readoutData2),
      .readoutCount(readoutCount2), .active(active2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // VRAM model: unwritten locations return a fixed address-derived pattern.
   function automatic logic [7:0] pat(input logic [11:0] a);
      return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h5C;
   endfunction

   logic [7:0] mem [0:4095];
   logic       wv  [0:4095];

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4096; i++) wv[i] <= 1'b0;
         ramRData <= 8'h00;
      end else begin
         if (ramWe) begin
            mem[ramAddr] <= ramWData;
            wv[ramAddr]  <= 1'b1;
         end
         ramRData <= wv[ramAddr] ? mem[ramAddr] : pat(ramAddr);
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_slot(input logic [2:0] k);
      int n;
      n = 0;
      while (readoutCount !== k && n < 16) begin
         tick();
         n++;
      end
      if (readoutCount !== k) begin
         total++; bad++;
         $display("FAIL wait_slot: count=%0d want=%0d", readoutCount, k);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++; if (readoutCount !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", readoutCount); end
      total++; if (active !== 1'b0) begin bad++; $display("FAIL rst_active got=%0b exp=0", active); end
      total++; if (ramWe !== 1'b0 || ramAddr !== 12'h000 || ramWData !== 8'h00) begin bad++; $display("FAIL rst_ram we=%0b addr=%h wd=%h exp 0", ramWe, ramAddr, ramWData); end
      total++; if (hostAck !== 1'b0 || hostRData !== 8'h00) begin bad++; $display("FAIL rst_host ack=%0b rd=%h exp 0", hostAck, hostRData); end
      total++; if (hostAck2 !== 1'b0 || hostRData2 !== 8'h00 || ramWData2 !== 8'h00 || readoutData2 !== 8'h00) begin bad++; $display("FAIL rst_dut2 ack=%0b rd=%h wd=%h ro=%h exp 0", hostAck2, hostRData2, ramWData2, readoutData2); end
      rst = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         total++; if (readoutCount !== 3'(i % 8)) begin bad++; $display("FAIL idle_count i=%0d got=%0d exp=%0d", i, readoutCount, i % 8); end
         total++; if (active !== 1'b0 || ramWe !== 1'b0 || hostAck !== 1'b0) begin bad++; $display("FAIL idle_outs i=%0d act=%0b we=%0b ack=%0b exp 0", i, active, ramWe, hostAck); end
      end
   endtask

   task automatic test_host_idle;
      int we_cnt;
      we_cnt = 0;
      wait_slot(3'd3);
      hostReq = 1'b1; hostWe = 1'b1; hostAddr = 12'h020; hostWData = 8'h5A;
      tick(); we_cnt += int'(ramWe);
      total++; if (ramWe !== 1'b1 || ramAddr !== 12'h020 || ramWData !== 8'h5A) begin bad++; $display("FAIL wr_grant we=%0b addr=%h wd=%h exp 1/020/5a", ramWe, ramAddr, ramWData); end
      total++; if (hostAck !== 1'b0) begin bad++; $display("FAIL wr_early_ack got=%0b exp=0", hostAck); end
      tick(); we_cnt += int'(ramWe);
      total++; if (hostAck !== 1'b1) begin bad++; $display("FAIL wr_ack got=%0b exp=1", hostAck); end
      hostReq = 1'b0;
      tick(); we_cnt += int'(ramWe);
      total++; if (hostAck !== 1'b0) begin bad++; $display("FAIL wr_ack_len got=%0b exp=0", hostAck); end
      hostReq = 1'b1; hostWe = 1'b0; hostAddr = 12'h020; hostWData = 8'h00;
      tick(); we_cnt += int'(ramWe);
      total++; if (ramAddr !== 12'h020 || hostAck !== 1'b0) begin bad++; $display("FAIL rd_grant addr=%h ack=%0b exp 020/0", ramAddr, hostAck); end
      tick(); we_cnt += int'(ramWe);
      total++; if (hostAck !== 1'b1 || hostRData !== 8'h5A) begin bad++; $display("FAIL rd_ack ack=%0b rd=%h exp 1/5a", hostAck, hostRData); end
      hostReq = 1'b0;
      tick(); we_cnt += int'(ramWe);
      total++; if (hostAck !== 1'b0 || hostRData !== 8'h5A) begin bad++; $display("FAIL rd_hold ack=%0b rd=%h exp 0/5a", hostAck, hostRData); end
      total++; if (we_cnt !== 1) begin bad++; $display("FAIL we_pulses got=%0d exp=1", we_cnt); end
   endtask

   task automatic test_line;
      int n_act, addr_bad, data_bad, we_bad, cnt_bad, gap_act;
      int slot, col;
      logic [11:0] a_c0s2, a_c0s6, a_c1s2, a_c79s6, ea;
      n_act = 0; addr_bad = 0; data_bad = 0; we_bad = 0; cnt_bad = 0; gap_act = 0;
      a_c0s2 = '0; a_c0s6 = '0; a_c1s2 = '0; a_c79s6 = '0;
      wait_slot(3'd7);
      fetchStart = 1'b1; rowBase = 12'h100;
      for (int n = 0; n < 640; n++) begin
         tick();
         slot = n % 8; col = n / 8;
         if (active === 1'b1) n_act++;
         if (readoutCount !== 3'(slot)) cnt_bad++;
         if (slot == 2 || slot == 6) begin
            ea = 12'h100 + 12'(2 * col) + ((slot == 6) ? 12'h001 : 12'h000);
            if (ramAddr !== ea) addr_bad++;
            if (ramWe !== 1'b0) we_bad++;
            if (slot == 2 && col == 0) a_c0s2 = ramAddr;
            if (slot == 6 && col == 0) a_c0s6 = ramAddr;
            if (slot == 2 && col == 1) a_c1s2 = ramAddr;
            if (slot == 6 && col == 79) a_c79s6 = ramAddr;
         end
         if (slot == 3 || slot == 7) begin
            ea = 12'h100 + 12'(2 * col) + ((slot == 7) ? 12'h001 : 12'h000);
            if (readoutData !== pat(ea)) data_bad++;
         end
      end
      total++; if (n_act !== 640) begin bad++; $display("FAIL line_len got=%0d exp=640", n_act); end
      total++; if (cnt_bad !== 0) begin bad++; $display("FAIL line_count errs=%0d exp=0", cnt_bad); end
      total++; if (a_c0s2 !== 12'h100) begin bad++; $display("FAIL chr0_addr got=%h exp=100", a_c0s2); end
      total++; if (a_c0s6 !== 12'h101) begin bad++; $display("FAIL atr0_addr got=%h exp=101", a_c0s6); end
      total++; if (a_c1s2 !== 12'h102) begin bad++; $display("FAIL chr1_addr got=%h exp=102", a_c1s2); end
      total++; if (a_c79s6 !== 12'h19F) begin bad++; $display("FAIL atr79_addr got=%h exp=19f", a_c79s6); end
      total++; if (addr_bad !== 0) begin bad++; $display("FAIL disp_addrs errs=%0d exp=0", addr_bad); end
      total++; if (we_bad !== 0) begin bad++; $display("FAIL disp_we errs=%0d exp=0", we_bad); end
      total++; if (data_bad !== 0) begin bad++; $display("FAIL readout_data errs=%0d exp=0", data_bad); end
      // fetchStart held through the last slot 7: ignored there, honoured one slot 7 later
      for (int n = 0; n < 8; n++) begin
         tick();
         if (active !== 1'b0) gap_act++;
      end
      total++; if (gap_act !== 0) begin bad++; $display("FAIL line_gap active_cycles=%0d exp=0", gap_act); end
      tick();
      total++; if (active !== 1'b1 || readoutCount !== 3'd0) begin bad++; $display("FAIL restart act=%0b cnt=%0d exp 1/0", active, readoutCount); end
      fetchStart = 1'b0;
   endtask

   task automatic test_host_during_active;
      int n;
      tick();
      hostReq = 1'b1; hostWe = 1'b0; hostAddr = 12'h300; hostWData = 8'h00;
      tick();
      total++; if (ramAddr !== 12'h100 || ramWe !== 1'b0 || hostAck !== 1'b0) begin bad++; $display("FAIL act_disp_wins addr=%h we=%0b ack=%0b exp 100/0/0", ramAddr, ramWe, hostAck); end
      tick();
      total++; if (ramAddr !== 12'h300 || hostAck !== 1'b0) begin bad++; $display("FAIL act_grant addr=%h ack=%0b exp 300/0", ramAddr, hostAck); end
      tick();
      total++; if (hostAck !== 1'b1 || hostRData !== pat(12'h300)) begin bad++; $display("FAIL act_ack ack=%0b rd=%h exp 1/%h", hostAck, hostRData, pat(12'h300)); end
      hostReq = 1'b0;
      tick();
      total++; if (hostAck !== 1'b0) begin bad++; $display("FAIL act_ack_len got=%0b exp=0", hostAck); end
      n = 0;
      while (active === 1'b1 && n < 700) begin
         tick();
         n++;
      end
      total++; if (active !== 1'b0) begin bad++; $display("FAIL line2_end active=%0b exp=0", active); end
   endtask

   task automatic test_wrap;
      int n_act, side_bad;
      int slot, col;
      logic [11:0] c0, c1, t0, t1;
      n_act = 0; side_bad = 0;
      c0 = '0; c1 = '0; t0 = '0; t1 = '0;
      wait_slot(3'd7);
      fetchStart2 = 1'b1; rowBase2 = 12'hFFE;
      tick();
      fetchStart2 = 1'b0;
      for (int n = 0; n < 16; n++) begin
         if (n > 0) tick();
         slot = n % 8; col = n / 8;
         if (active2 === 1'b1) n_act++;
         if (ramWe2 !== 1'b0 || hostAck2 !== 1'b0 || readoutCount2 !== 3'(slot)) side_bad++;
         if (slot == 2 && col == 0) c0 = ramAddr2;
         if (slot == 2 && col == 1) c1 = ramAddr2;
         if (slot == 6 && col == 0) t0 = ramAddr2;
         if (slot == 6 && col == 1) t1 = ramAddr2;
      end
      tick();
      total++; if (n_act !== 16 || active2 !== 1'b0) begin bad++; $display("FAIL wrap_len got=%0d end_act=%0b exp 16/0", n_act, active2); end
      total++; if (c0 !== 12'hFFE || c1 !== 12'h000) begin bad++; $display("FAIL wrap_chr got=%h,%h exp ffe,000", c0, c1); end
      total++; if (t0 !== 12'hFFF || t1 !== 12'h001) begin bad++; $display("FAIL wrap_atr got=%h,%h exp fff,001", t0, t1); end
      total++; if (side_bad !== 0) begin bad++; $display("FAIL wrap_side errs=%0d exp=0", side_bad); end
   endtask

   task automatic test_reset_mid;
      int side_bad;
      side_bad = 0;
      wait_slot(3'd7);
      fetchStart = 1'b1; rowBase = 12'h100;
      tick();
      fetchStart = 1'b0;
      tick();
      tick();
      hostReq = 1'b1; hostWe = 1'b1; hostAddr = 12'h040; hostWData = 8'h77;
      tick();
      total++; if (ramWe !== 1'b1 || ramAddr !== 12'h040 || active !== 1'b1) begin bad++; $display("FAIL pre_rst we=%0b addr=%h act=%0b exp 1/040/1", ramWe, ramAddr, active); end
      #2 rst = 1'b1;
      #1;
      total++; if (readoutCount !== 3'd0 || active !== 1'b0) begin bad++; $display("FAIL mid_rst_ctl cnt=%0d act=%0b exp 0/0", readoutCount, active); end
      total++; if (ramWe !== 1'b0 || ramAddr !== 12'h000 || ramWData !== 8'h00) begin bad++; $display("FAIL mid_rst_ram we=%0b addr=%h wd=%h exp 0", ramWe, ramAddr, ramWData); end
      total++; if (hostAck !== 1'b0 || hostRData !== 8'h00) begin bad++; $display("FAIL mid_rst_host ack=%0b rd=%h exp 0", hostAck, hostRData); end
      @(posedge clk);
      hostReq = 1'b0;
      #1 rst = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         tick();
         if (readoutCount !== 3'(i % 8) || active !== 1'b0 || hostAck !== 1'b0 || ramWe !== 1'b0) side_bad++;
      end
      total++; if (side_bad !== 0) begin bad++; $display("FAIL post_rst errs=%0d exp=0", side_bad); end
   endtask

   initial begin
      fetchStart = 1'b0; rowBase = '0;
      hostReq = 1'b0; hostWe = 1'b0; hostAddr = '0; hostWData = '0;
      fetchStart2 = 1'b0; rowBase2 = '0;
      zero1 = 1'b0; zero12 = '0; zero8 = '0;
      test_reset();
      test_host_idle();
      test_line();
      test_host_during_active();
      test_wrap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
